// File: rtl/ysyx_25060173_instruction_encoder_if.sv
// Request/response bundle for the RV32I instruction encoder.
// The producer of requests and consumer of encoded words uses the master
// view; the encoder itself uses the slave view.
interface ysyx_25060173_instruction_encoder_if;
  logic        req_valid;
  logic        req_ready;
  logic [5:0]  req_op;
  logic [4:0]  req_rd;
  logic [4:0]  req_rs1;
  logic [4:0]  req_rs2;
  logic [31:0] req_imm;

  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic        out_last;

  logic        err;
  logic [15:0] word_cnt;

  modport slave (
    input  req_valid, req_op, req_rd, req_rs1, req_rs2, req_imm, out_ready,
    output req_ready, out_valid, out_inst, out_last, err, word_cnt
  );

  modport master (
    output req_valid, req_op, req_rd, req_rs1, req_rs2, req_imm, out_ready,
    input  req_ready, out_valid, out_inst, out_last, err, word_cnt
  );
endinterface

// File: rtl/ysyx_25060173_instruction_encoder.sv
// RV32I instruction encoder: turns an (op, rd, rs1, rs2, imm) request into one
// encoded 32-bit word, or two words for a li that needs lui+addi. Requests with
// an unknown op or an out-of-range immediate are consumed and flagged on err.
module ysyx_25060173_instruction_encoder (
  input logic                                clk,
  input logic                                rst,
  ysyx_25060173_instruction_encoder_if.slave bus
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [31:0] EBREAK    = 32'h00100073;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // IDLE: nothing held; ONE: holding the final word; FIRST: holding the lui
  // half of a li while the addi half waits in hold_q.
  typedef enum logic [1:0] {IDLE, ONE, FIRST} state_e;

  state_e      state_q, state_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] hold_q, hold_d;
  logic        err_q, err_d;
  logic [15:0] wordCnt_q, wordCnt_d;

  logic        reqReady;
  logic        accept;
  logic        drain;

  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm;
  logic        fitsI, fitsShift, fitsB, fitsJ;
  logic [19:0] liUpper;

  logic [31:0] encFirst;
  logic [31:0] encSecond;
  logic        encTwo;
  logic        encBad;

  // Instruction format builders.
  function automatic logic [31:0] fmtR(input logic [6:0] f7, input logic [4:0] r2,
                                       input logic [4:0] r1, input logic [2:0] f3,
                                       input logic [4:0] rdv, input logic [6:0] opc);
    return {f7, r2, r1, f3, rdv, opc};
  endfunction

  function automatic logic [31:0] fmtI(input logic [11:0] i12, input logic [4:0] r1,
                                       input logic [2:0] f3, input logic [4:0] rdv,
                                       input logic [6:0] opc);
    return {i12, r1, f3, rdv, opc};
  endfunction

  function automatic logic [31:0] fmtS(input logic [11:0] i12, input logic [4:0] r2,
                                       input logic [4:0] r1, input logic [2:0] f3);
    return {i12[11:5], r2, r1, f3, i12[4:0], OPC_STORE};
  endfunction

  // Branch offset is passed without its always-zero bit 0.
  function automatic logic [31:0] fmtB(input logic [12:1] b, input logic [4:0] r2,
                                       input logic [4:0] r1, input logic [2:0] f3);
    return {b[12], b[10:5], r2, r1, f3, b[4:1], b[11], OPC_BRANCH};
  endfunction

  function automatic logic [31:0] fmtU(input logic [19:0] u, input logic [4:0] rdv,
                                       input logic [6:0] opc);
    return {u, rdv, opc};
  endfunction

  // Jump offset is passed without its always-zero bit 0.
  function automatic logic [31:0] fmtJ(input logic [20:1] j, input logic [4:0] rdv);
    return {j[20], j[10:1], j[11], j[19:12], rdv, OPC_JAL};
  endfunction

  assign rd  = bus.req_rd;
  assign rs1 = bus.req_rs1;
  assign rs2 = bus.req_rs2;
  assign imm = bus.req_imm;

  // A signed value fits in N bits when all bits from N-1 upward agree.
  assign fitsI     = (&imm[31:11]) | ~(|imm[31:11]);
  assign fitsShift = ~(|imm[31:5]);
  assign fitsB     = ((&imm[31:12]) | ~(|imm[31:12])) & ~imm[0];
  assign fitsJ     = ((&imm[31:20]) | ~(|imm[31:20])) & ~imm[0];

  // Upper part of (imm + 0x800): the carry into bit 12 is exactly imm[11].
  assign liUpper = imm[31:12] + {19'd0, imm[11]};

  // Encode the incoming request and decide whether it is legal.
  always_comb begin
    encFirst  = 32'd0;
    encSecond = 32'd0;
    encTwo    = 1'b0;
    encBad    = 1'b0;
    case (bus.req_op)
      6'd0:  encFirst = fmtR(F7_ZERO, rs2, rs1, 3'd0, rd, OPC_OP);
      6'd1:  encFirst = fmtR(F7_ALT,  rs2, rs1, 3'd0, rd, OPC_OP);
      6'd2:  encFirst = fmtR(F7_ZERO, rs2, rs1, 3'd1, rd, OPC_OP);
      6'd3:  encFirst = fmtR(F7_ZERO, rs2, rs1, 3'd2, rd, OPC_OP);
      6'd4:  encFirst = fmtR(F7_ZERO, rs2, rs1, 3'd3, rd, OPC_OP);
      6'd5:  encFirst = fmtR(F7_ZERO, rs2, rs1, 3'd4, rd, OPC_OP);
      6'd6:  encFirst = fmtR(F7_ZERO, rs2, rs1, 3'd5, rd, OPC_OP);
      6'd7:  encFirst = fmtR(F7_ALT,  rs2, rs1, 3'd5, rd, OPC_OP);
      6'd8:  encFirst = fmtR(F7_ZERO, rs2, rs1, 3'd6, rd, OPC_OP);
      6'd9:  encFirst = fmtR(F7_ZERO, rs2, rs1, 3'd7, rd, OPC_OP);
      6'd10: begin encBad = ~fitsI; encFirst = fmtI(imm[11:0], rs1, 3'd0, rd, OPC_IMM); end
      6'd11: begin encBad = ~fitsI; encFirst = fmtI(imm[11:0], rs1, 3'd2, rd, OPC_IMM); end
      6'd12: begin encBad = ~fitsI; encFirst = fmtI(imm[11:0], rs1, 3'd3, rd, OPC_IMM); end
      6'd13: begin encBad = ~fitsI; encFirst = fmtI(imm[11:0], rs1, 3'd4, rd, OPC_IMM); end
      6'd14: begin encBad = ~fitsI; encFirst = fmtI(imm[11:0], rs1, 3'd6, rd, OPC_IMM); end
      6'd15: begin encBad = ~fitsI; encFirst = fmtI(imm[11:0], rs1, 3'd7, rd, OPC_IMM); end
      6'd16: begin encBad = ~fitsShift; encFirst = fmtR(F7_ZERO, imm[4:0], rs1, 3'd1, rd, OPC_IMM); end
      6'd17: begin encBad = ~fitsShift; encFirst = fmtR(F7_ZERO, imm[4:0], rs1, 3'd5, rd, OPC_IMM); end
      6'd18: begin encBad = ~fitsShift; encFirst = fmtR(F7_ALT,  imm[4:0], rs1, 3'd5, rd, OPC_IMM); end
      6'd19: begin encBad = ~fitsI; encFirst = fmtI(imm[11:0], rs1, 3'd0, rd, OPC_LOAD); end
      6'd20: begin encBad = ~fitsI; encFirst = fmtI(imm[11:0], rs1, 3'd1, rd, OPC_LOAD); end
      6'd21: begin encBad = ~fitsI; encFirst = fmtI(imm[11:0], rs1, 3'd2, rd, OPC_LOAD); end
      6'd22: begin encBad = ~fitsI; encFirst = fmtI(imm[11:0], rs1, 3'd4, rd, OPC_LOAD); end
      6'd23: begin encBad = ~fitsI; encFirst = fmtI(imm[11:0], rs1, 3'd5, rd, OPC_LOAD); end
      6'd24: begin encBad = ~fitsI; encFirst = fmtS(imm[11:0], rs2, rs1, 3'd0); end
      6'd25: begin encBad = ~fitsI; encFirst = fmtS(imm[11:0], rs2, rs1, 3'd1); end
      6'd26: begin encBad = ~fitsI; encFirst = fmtS(imm[11:0], rs2, rs1, 3'd2); end
      6'd27: begin encBad = ~fitsB; encFirst = fmtB(imm[12:1], rs2, rs1, 3'd0); end
      6'd28: begin encBad = ~fitsB; encFirst = fmtB(imm[12:1], rs2, rs1, 3'd1); end
      6'd29: begin encBad = ~fitsB; encFirst = fmtB(imm[12:1], rs2, rs1, 3'd4); end
      6'd30: begin encBad = ~fitsB; encFirst = fmtB(imm[12:1], rs2, rs1, 3'd5); end
      6'd31: begin encBad = ~fitsB; encFirst = fmtB(imm[12:1], rs2, rs1, 3'd6); end
      6'd32: begin encBad = ~fitsB; encFirst = fmtB(imm[12:1], rs2, rs1, 3'd7); end
      6'd33: begin encBad = ~fitsJ; encFirst = fmtJ(imm[20:1], rd); end
      6'd34: begin encBad = ~fitsI; encFirst = fmtI(imm[11:0], rs1, 3'd0, rd, OPC_JALR); end
      6'd35: encFirst = fmtU(imm[31:12], rd, OPC_LUI);
      6'd36: encFirst = fmtU(imm[31:12], rd, OPC_AUIPC);
      6'd37: encFirst = EBREAK;
      6'd38: begin
        if (fitsI) begin
          encFirst = fmtI(imm[11:0], 5'd0, 3'd0, rd, OPC_IMM);
        end else if (imm[11:0] == 12'd0) begin
          encFirst = fmtU(imm[31:12], rd, OPC_LUI);
        end else begin
          encTwo    = 1'b1;
          encFirst  = fmtU(liUpper, rd, OPC_LUI);
          encSecond = fmtI(imm[11:0], rd, 3'd0, rd, OPC_IMM);
        end
      end
      default: encBad = 1'b1;
    endcase
  end

  // State and datapath registers; reset drops any held or pending word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      inst_q    <= 32'd0;
      hold_q    <= 32'd0;
      err_q     <= 1'b0;
      wordCnt_q <= 16'd0;
    end else begin
      state_q   <= state_d;
      inst_q    <= inst_d;
      hold_q    <= hold_d;
      err_q     <= err_d;
      wordCnt_q <= wordCnt_d;
    end
  end

  // Next state: accept new requests, drain held words, flag rejections.
  always_comb begin
    state_d   = state_q;
    inst_d    = inst_q;
    hold_d    = hold_q;
    err_d     = 1'b0;
    wordCnt_d = wordCnt_q + {15'd0, drain};
    case (state_q)
      FIRST: begin
        if (bus.out_ready) begin
          state_d = ONE;
          inst_d  = hold_q;
          hold_d  = 32'd0;
        end
      end
      ONE: begin
        if (bus.out_ready && !accept) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (accept) begin
      if (encBad) begin
        state_d = IDLE;
        err_d   = 1'b1;
      end else begin
        inst_d  = encFirst;
        hold_d  = encSecond;
        state_d = encTwo ? FIRST : ONE;
      end
    end
  end

  // Handshake and output drive derived from the current state.
  always_comb begin
    reqReady = ~rst & ((state_q == IDLE) | ((state_q == ONE) & bus.out_ready));
    accept   = bus.req_valid & reqReady;
    drain    = (state_q != IDLE) & bus.out_ready;
  end

  assign bus.req_ready = reqReady;
  assign bus.out_valid = (state_q != IDLE);
  assign bus.out_last  = (state_q == ONE);
  assign bus.out_inst  = inst_q;
  assign bus.err       = err_q;
  assign bus.word_cnt  = wordCnt_q;

endmodule

// File: tb/tb_ysyx_25060173_instruction_encoder.sv
// Directed bench for the RV32I instruction encoder: single-word encodes, li
// expansion with back-pressure, rejections, reset mid-expansion and streaming.
module tb_ysyx_25060173_instruction_encoder;

  logic clk;
  logic rst;
  int   testsRun;
  int   testsFailed;
  int   expCnt;

  ysyx_25060173_instruction_encoder_if bus ();

  ysyx_25060173_instruction_encoder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [5:0] op, input logic [4:0] rd,
                               input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [31:0] imm);
    bus.req_op    = op;
    bus.req_rd    = rd;
    bus.req_rs1   = rs1;
    bus.req_rs2   = rs2;
    bus.req_imm   = imm;
    bus.req_valid = 1'b1;
  endtask

  task automatic encodeSingle(input string tag, input logic [5:0] op, input logic [4:0] rd,
                              input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [31:0] imm, input logic [31:0] expWord);
    bus.out_ready = 1'b1;
    applyStimulus(op, rd, rs1, rs2, imm);
    #1;
    checkOutput({tag, ".ready"}, {31'd0, bus.req_ready}, 32'd1);
    nextCycle();
    bus.req_valid = 1'b0;
    #1;
    checkOutput({tag, ".valid"}, {31'd0, bus.out_valid}, 32'd1);
    checkOutput({tag, ".inst"}, bus.out_inst, expWord);
    checkOutput({tag, ".last"}, {31'd0, bus.out_last}, 32'd1);
    checkOutput({tag, ".err"}, {31'd0, bus.err}, 32'd0);
    nextCycle();
    expCnt++;
    checkOutput({tag, ".idle"}, {31'd0, bus.out_valid}, 32'd0);
    checkOutput({tag, ".cnt"}, {16'd0, bus.word_cnt}, expCnt);
  endtask

  task automatic encodeLi(input string tag, input logic [4:0] rd, input logic [31:0] imm,
                          input logic [31:0] luiWord, input logic [31:0] addiWord,
                          input int stall);
    bus.out_ready = (stall == 0);
    applyStimulus(6'd38, rd, 5'd0, 5'd0, imm);
    #1;
    checkOutput({tag, ".ready"}, {31'd0, bus.req_ready}, 32'd1);
    nextCycle();
    bus.req_valid = 1'b0;
    for (int i = 0; i < stall; i++) begin
      #1;
      checkOutput({tag, ".stallValid"}, {31'd0, bus.out_valid}, 32'd1);
      checkOutput({tag, ".stallInst"}, bus.out_inst, luiWord);
      checkOutput({tag, ".stallLast"}, {31'd0, bus.out_last}, 32'd0);
      checkOutput({tag, ".stallReady"}, {31'd0, bus.req_ready}, 32'd0);
      checkOutput({tag, ".stallCnt"}, {16'd0, bus.word_cnt}, expCnt);
      nextCycle();
    end
    bus.out_ready = 1'b1;
    #1;
    checkOutput({tag, ".luiValid"}, {31'd0, bus.out_valid}, 32'd1);
    checkOutput({tag, ".lui"}, bus.out_inst, luiWord);
    checkOutput({tag, ".luiLast"}, {31'd0, bus.out_last}, 32'd0);
    nextCycle();
    expCnt++;
    checkOutput({tag, ".addiValid"}, {31'd0, bus.out_valid}, 32'd1);
    checkOutput({tag, ".addi"}, bus.out_inst, addiWord);
    checkOutput({tag, ".addiLast"}, {31'd0, bus.out_last}, 32'd1);
    nextCycle();
    expCnt++;
    checkOutput({tag, ".idle"}, {31'd0, bus.out_valid}, 32'd0);
    checkOutput({tag, ".cnt"}, {16'd0, bus.word_cnt}, expCnt);
  endtask

  task automatic rejectCase(input string tag, input logic [5:0] op, input logic [31:0] imm);
    bus.out_ready = 1'b1;
    applyStimulus(op, 5'd1, 5'd2, 5'd3, imm);
    #1;
    checkOutput({tag, ".ready"}, {31'd0, bus.req_ready}, 32'd1);
    nextCycle();
    bus.req_valid = 1'b0;
    #1;
    checkOutput({tag, ".err"}, {31'd0, bus.err}, 32'd1);
    checkOutput({tag, ".noValid"}, {31'd0, bus.out_valid}, 32'd0);
    nextCycle();
    checkOutput({tag, ".errDrop"}, {31'd0, bus.err}, 32'd0);
    checkOutput({tag, ".stillNoValid"}, {31'd0, bus.out_valid}, 32'd0);
    checkOutput({tag, ".cnt"}, {16'd0, bus.word_cnt}, expCnt);
  endtask

  // Main directed sequence.
  initial begin
    testsRun      = 0;
    testsFailed   = 0;
    expCnt        = 0;
    rst           = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_op    = 6'd10;
    bus.req_rd    = 5'd1;
    bus.req_rs1   = 5'd0;
    bus.req_rs2   = 5'd0;
    bus.req_imm   = 32'd5;
    bus.out_ready = 1'b1;

    nextCycle();
    nextCycle();
    checkOutput("rst.reqReady", {31'd0, bus.req_ready}, 32'd0);
    checkOutput("rst.outValid", {31'd0, bus.out_valid}, 32'd0);
    checkOutput("rst.outInst", bus.out_inst, 32'd0);
    checkOutput("rst.outLast", {31'd0, bus.out_last}, 32'd0);
    checkOutput("rst.err", {31'd0, bus.err}, 32'd0);
    checkOutput("rst.wordCnt", {16'd0, bus.word_cnt}, 32'd0);
    rst           = 1'b0;
    bus.req_valid = 1'b0;
    #1;
    checkOutput("idle.reqReady", {31'd0, bus.req_ready}, 32'd1);

    encodeSingle("addi", 6'd10, 5'd1, 5'd0, 5'd0, 32'd5, 32'h00500093);
    encodeSingle("ebreak", 6'd37, 5'd5, 5'd3, 5'd7, 32'd0, 32'h00100073);
    encodeSingle("jal", 6'd33, 5'd0, 5'd0, 5'd0, 32'd0, 32'h0000006F);
    encodeSingle("beq", 6'd27, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC, 32'hFE208EE3);
    encodeSingle("sw", 6'd26, 5'd0, 5'd1, 5'd2, 32'd8, 32'h0020A423);
    encodeSingle("sra", 6'd7, 5'd3, 5'd1, 5'd2, 32'd0, 32'h4020D1B3);
    encodeSingle("lui", 6'd35, 5'd7, 5'd0, 5'd0, 32'hABCDE123, 32'hABCDE3B7);

    encodeLi("liTwo", 5'd5, 32'h12345678, 32'h123452B7, 32'h67828293, 3);
    encodeLi("liRound", 5'd1, 32'h00000FFF, 32'h000010B7, 32'hFFF08093, 0);
    encodeSingle("li2047", 6'd38, 5'd1, 5'd0, 5'd0, 32'd2047, 32'h7FF00093);
    encodeSingle("li4096", 6'd38, 5'd1, 5'd0, 5'd0, 32'h00001000, 32'h000010B7);

    rejectCase("rejBeq", 6'd27, 32'd3);
    rejectCase("rejSlli", 6'd16, 32'd32);
    rejectCase("rejAddi", 6'd10, 32'd2048);
    rejectCase("rejOp50", 6'd50, 32'd0);

    // Reset while the lui half is held and the addi half is pending.
    bus.out_ready = 1'b0;
    applyStimulus(6'd38, 5'd5, 5'd0, 5'd0, 32'h12345678);
    nextCycle();
    bus.req_valid = 1'b0;
    checkOutput("first.valid", {31'd0, bus.out_valid}, 32'd1);
    checkOutput("first.last", {31'd0, bus.out_last}, 32'd0);
    rst = 1'b1;
    #1;
    checkOutput("first.rstReady", {31'd0, bus.req_ready}, 32'd0);
    nextCycle();
    expCnt = 0;
    checkOutput("first.rstValid", {31'd0, bus.out_valid}, 32'd0);
    checkOutput("first.rstCnt", {16'd0, bus.word_cnt}, expCnt);
    checkOutput("first.rstInst", bus.out_inst, 32'd0);
    rst           = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      nextCycle();
      checkOutput("first.noAddi", {31'd0, bus.out_valid}, 32'd0);
      checkOutput("first.cntHeld", {16'd0, bus.word_cnt}, expCnt);
    end

    // Four back-to-back adds streaming at one word per cycle.
    bus.out_ready = 1'b1;
    applyStimulus(6'd0, 5'd3, 5'd1, 5'd2, 32'd0);
    #1;
    checkOutput("stream.ready0", {31'd0, bus.req_ready}, 32'd1);
    nextCycle();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) bus.req_valid = 1'b0;
      #1;
      checkOutput("stream.valid", {31'd0, bus.out_valid}, 32'd1);
      checkOutput("stream.inst", bus.out_inst, 32'h002081B3);
      checkOutput("stream.ready", {31'd0, bus.req_ready}, 32'd1);
      nextCycle();
      expCnt++;
    end
    checkOutput("stream.idle", {31'd0, bus.out_valid}, 32'd0);
    checkOutput("stream.cnt", {16'd0, bus.word_cnt}, expCnt);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
